// File: rtl/alu_pipe.sv
// Single-issue ALU with valid/ready handshake on both sides; MUL is iterative shift-add (W cycles).
// Non-MUL results appear one cycle after accept; a held result stalls input until the consumer retires it.
module alu_pipe #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [W-1:0] InputA,
  input  logic [W-1:0] InputB,
  input  logic [2:0]   OP,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [W-1:0] Out,
  output logic         Zero,
  output logic         Carry,
  output logic         Neg
);

  localparam int SW = $clog2(W);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_LSH = 3'd1;
  localparam logic [2:0] OP_RSH = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;

  typedef enum logic [1:0] {IDLE, MULT, HOLD} state_t;

  state_t          state;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  mcand;
  logic [W-1:0]    mplier;
  logic [SW-1:0]   cnt;

  logic            accept;
  logic [SW-1:0]   sh;
  logic [W:0]      sum;
  logic [W:0]      diff;
  logic [2*W-1:0]  lwide;
  logic [2*W-1:0]  rwide;
  logic [2*W-1:0]  acc_next;
  logic [W-1:0]    res;
  logic            res_c;
  logic            wr_en;
  logic [W-1:0]    wr_val;
  logic            wr_c;

  // InReady in HOLD follows OutReady so a retire and a new accept share one edge.
  assign InReady  = (state == IDLE) || ((state == HOLD) && OutReady);
  assign OutValid = (state == HOLD);
  assign accept   = InValid && InReady;

  always_comb begin
    sh       = InputB[SW-1:0];
    sum      = {1'b0, InputA} + {1'b0, InputB};
    diff     = {1'b0, InputA} - {1'b0, InputB};
    lwide    = {{W{1'b0}}, InputA} << sh;
    rwide    = {InputA, {W{1'b0}}} >> sh;
    acc_next = mplier[0] ? (acc + mcand) : acc;
    res      = '0;
    res_c    = 1'b0;
    unique case (OP)
      OP_ADD: begin res = sum[W-1:0];       res_c = sum[W];      end
      OP_SUB: begin res = diff[W-1:0];      res_c = diff[W];     end
      // Bit W of lwide / bit W-1 of rwide hold the last bit shifted out; both are 0 for a zero shift.
      OP_LSH: begin res = lwide[W-1:0];     res_c = lwide[W];    end
      OP_RSH: begin res = rwide[2*W-1:W];   res_c = rwide[W-1];  end
      OP_XOR: res = InputA ^ InputB;
      OP_AND: res = InputA & InputB;
      default: res = '0;
    endcase

    wr_en  = 1'b0;
    wr_val = res;
    wr_c   = res_c;
    if (state == MULT) begin
      wr_en  = (cnt == SW'(W - 1));
      wr_val = acc_next[W-1:0];
      wr_c   = |acc_next[2*W-1:W];
    end else if (accept && (OP != OP_MUL)) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      Out    <= '0;
      Zero   <= 1'b1;
      Carry  <= 1'b0;
      Neg    <= 1'b0;
    end else begin
      if (wr_en) begin
        Out   <= wr_val;
        Zero  <= (wr_val == '0);
        Carry <= wr_c;
        Neg   <= wr_val[W-1];
      end
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (OP == OP_MUL) begin
              state  <= MULT;
              acc    <= '0;
              mcand  <= {{W{1'b0}}, InputA};
              mplier <= InputB;
              cnt    <= '0;
            end else begin
              state <= HOLD;
            end
          end else if ((state == HOLD) && OutReady) begin
            state <= IDLE;
          end
        end
        MULT: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == SW'(W - 1)) state <= HOLD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (W=8): inputs driven and outputs sampled on the falling clock edge.
module tb_alu_pipe;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] InputA;
  logic [W-1:0] InputB;
  logic [2:0]   OP;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] Out;
  logic         Zero;
  logic         Carry;
  logic         Neg;
  logic [11:0]  obs;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_pipe #(.W(W)) dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InputA(InputA), .InputB(InputB), .OP(OP), .OutValid(OutValid),
    .OutReady(OutReady), .Out(Out), .Zero(Zero), .Carry(Carry), .Neg(Neg)
  );

  // {OutValid, Out, Zero, Carry, Neg}
  assign obs = {OutValid, Out, Zero, Carry, Neg};

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    InValid = v;
    OP      = op;
    InputA  = a;
    InputB  = b;
  endtask

  task automatic test_reset;
    Reset    = 1'b1;
    OutReady = 1'b1;
    drive(1'b1, 3'd0, 8'h11, 8'h22);
    repeat (2) @(negedge CLK);
    checks++;
    if (obs !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, {1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
    end
    Reset = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge CLK);
    checks++;
    if ({InReady, OutValid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=10", {InReady, OutValid});
    end
  endtask

  task automatic test_add;
    drive(1'b1, 3'd0, 8'hFF, 8'h01);
    @(negedge CLK);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    checks++;
    if (obs !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_wrap got=%h exp=%h", obs, {1'b1, 8'h00, 1'b1, 1'b1, 1'b0});
    end
    @(negedge CLK);
    checks++;
    if ({OutValid, Out} !== {1'b0, 8'h00}) begin
      failures++;
      $display("FAIL add_retire got=%h exp=%h", {OutValid, Out}, {1'b0, 8'h00});
    end
  endtask

  task automatic test_sub_shift;
    drive(1'b1, 3'd5, 8'h03, 8'h05);
    @(negedge CLK);
    checks++;
    if (obs !== {1'b1, 8'hFE, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL sub_borrow got=%h exp=%h", obs, {1'b1, 8'hFE, 1'b0, 1'b1, 1'b1});
    end
    drive(1'b1, 3'd2, 8'h81, 8'h01);
    @(negedge CLK);
    checks++;
    if (obs !== {1'b1, 8'h40, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rsh_one got=%h exp=%h", obs, {1'b1, 8'h40, 1'b0, 1'b1, 1'b0});
    end
    drive(1'b1, 3'd1, 8'h81, 8'h00);
    @(negedge CLK);
    checks++;
    if (obs !== {1'b1, 8'h81, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL lsh_zero got=%h exp=%h", obs, {1'b1, 8'h81, 1'b0, 1'b0, 1'b1});
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    logic [2:0] t_op [12] = '{3'd0, 3'd3, 3'd4, 3'd1, 3'd1, 3'd2, 3'd2, 3'd5, 3'd7, 3'd1, 3'd2, 3'd0};
    logic [7:0] t_a  [12] = '{8'h7F, 8'hA5, 8'hF0, 8'h81, 8'h40, 8'h04, 8'h01, 8'h05, 8'hFF, 8'h01, 8'h80, 8'h80};
    logic [7:0] t_b  [12] = '{8'h01, 8'h0F, 8'h3C, 8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'hFF, 8'hF9, 8'h07, 8'h80};
    logic [7:0] t_r  [12] = '{8'h80, 8'hAA, 8'h30, 8'h02, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 8'h01, 8'h00};
    logic       t_c  [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [11:0] exp;
    OutReady = 1'b1;
    drive(1'b1, t_op[0], t_a[0], t_b[0]);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      exp = {1'b1, t_r[i], (t_r[i] == 8'h00), t_c[i], t_r[i][7]};
      checks++;
      if ({InReady, obs} !== {1'b1, exp}) begin
        failures++;
        $display("FAIL b2b_%0d got=%h exp=%h", i, {InReady, obs}, {1'b1, exp});
      end
      if (i < 11) drive(1'b1, t_op[i+1], t_a[i+1], t_b[i+1]);
      else        drive(1'b0, 3'd0, 8'h00, 8'h00);
    end
    @(negedge CLK);
  endtask

  task automatic test_backpressure;
    OutReady = 1'b0;
    drive(1'b1, 3'd0, 8'h02, 8'h03);
    @(negedge CLK);
    drive(1'b1, 3'd3, 8'h3C, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({InReady, obs} !== {1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold_%0d got=%h exp=%h", k, {InReady, obs}, {1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0});
      end
      @(negedge CLK);
    end
    OutReady = 1'b1;
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      failures++;
      $display("FAIL bp_passthru_ready got=%b exp=1", InReady);
    end
    @(negedge CLK);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    checks++;
    if (obs !== {1'b1, 8'hC3, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL bp_xor got=%h exp=%h", obs, {1'b1, 8'hC3, 1'b0, 1'b0, 1'b1});
    end
    @(negedge CLK);
    checks++;
    if ({OutValid, Out} !== {1'b0, 8'hC3}) begin
      failures++;
      $display("FAIL bp_retain got=%h exp=%h", {OutValid, Out}, {1'b0, 8'hC3});
    end
  endtask

  task automatic test_mul;
    logic [7:0] m_a [3] = '{8'h10, 8'hFF, 8'h0F};
    logic [7:0] m_b [3] = '{8'h11, 8'hFF, 8'h0E};
    logic [7:0] m_r [3] = '{8'h10, 8'h01, 8'hD2};
    logic       m_c [3] = '{1'b1, 1'b1, 1'b0};
    logic [11:0] exp;
    OutReady = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 3'd6, m_a[j], m_b[j]);
      @(negedge CLK);
      // Operands scrambled after acceptance must not disturb the product.
      drive(1'b0, 3'd0, 8'h5A, 8'hA5);
      for (int k = 1; k <= 8; k++) begin
        checks++;
        if ({InReady, OutValid} !== 2'b00) begin
          failures++;
          $display("FAIL mul%0d_busy_c%0d got=%b exp=00", j, k, {InReady, OutValid});
        end
        @(negedge CLK);
      end
      exp = {1'b1, m_r[j], (m_r[j] == 8'h00), m_c[j], m_r[j][7]};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL mul%0d_result got=%h exp=%h", j, obs, exp);
      end
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mul;
    int seen;
    OutReady = 1'b1;
    drive(1'b1, 3'd6, 8'h10, 8'h11);
    @(negedge CLK);
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    repeat (3) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    checks++;
    if ({InReady, obs} !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mul_reset got=%h exp=%h", {InReady, obs}, {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (OutValid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL mul_reset_no_result got=%0d exp=0", seen);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset    = 1'b1;
    OutReady = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge CLK);
    test_reset;
    test_add;
    test_sub_shift;
    test_back_to_back;
    test_backpressure;
    test_mul;
    test_reset_mul;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: W, default 8, datapath width in bits; SHALL be a power of two, 4 to 64.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset, sampled on rising CLK edge.
REQ-004 Port: InValid  input  1  request valid.
REQ-005 Port: InReady  output  1  block accepts a request this cycle.
REQ-006 Port: InputA  input  W  operand A.
REQ-007 Port: InputB  input  W  operand B; for shifts, InputB[log2(W)-1:0] is the shift amount, upper bits ignored.
REQ-008 Port: OP  input  3  opcode: 0 ADD, 1 LSH, 2 RSH, 3 XOR, 4 AND, 5 SUB, 6 MUL, 7 NOP.
REQ-009 Port: OutValid  output  1  result valid.
REQ-010 Port: OutReady  input  1  consumer takes the result this cycle.
REQ-011 Port: Out  output  W  registered result.
REQ-012 Port: Zero  output  1  registered; 1 iff Out == 0.
REQ-013 Port: Carry  output  1  registered carry/borrow/overflow flag, per REQ-020.
REQ-014 Port: Neg  output  1  registered; equals Out[W-1].

Function
REQ-015 Handshake: request accepted on a cycle with InValid=1 and InReady=1; result transferred on a cycle with OutValid=1 and OutReady=1.
REQ-016 FSM states: IDLE, MULT, HOLD; InReady=1 only in IDLE, or in HOLD on a cycle with OutReady=1 (pass-through: retire and accept on the same edge).
REQ-017 Transitions: IDLE/HOLD accepting non-MUL -> HOLD; IDLE/HOLD accepting MUL -> MULT; MULT after W iterations -> HOLD; HOLD with OutReady=1 and no accept -> IDLE; HOLD with OutReady=0 -> HOLD.
REQ-018 Latency: non-MUL result has OutValid=1 on the cycle after acceptance; MUL result has OutValid=1 exactly W+1 cycles after acceptance; InReady=0 throughout MULT.
REQ-019 Operations (modulo 2^W): ADD A+B; SUB A-B; XOR A^B; AND A&B; LSH A<<s, zero-fill; RSH logical A>>s, zero-fill; MUL low W bits of A*B via iterative shift-add, one multiplier bit per cycle; NOP Out=0.
REQ-020 Carry: ADD carry-out of bit W-1; SUB 1 iff A<B unsigned (borrow); LSH last bit shifted out of bit W-1; RSH last bit shifted out of bit 0; MUL 1 iff high W bits of the 2W-bit product are nonzero; XOR/AND/NOP 0; shift amount 0 -> Carry 0, Out=A.
REQ-021 Out, Zero, Carry, Neg SHALL be held stable while OutValid=1 and OutReady=0; InputA/InputB/OP changes are ignored except on an accept cycle.
REQ-022 Operands SHALL be captured on acceptance; source may change them freely afterwards, including during MULT.
REQ-023 When OutValid=0, Out/Zero/Carry/Neg retain their last values (Zero reflects retained Out); consumer SHALL NOT rely on them.
REQ-024 OutReady asserted with OutValid=0 SHALL have no effect; InValid while InReady=0 SHALL have no effect (request not accepted; source holds it).

Reset
REQ-025 On Reset=1 at a clock edge: state -> IDLE, OutValid=0, Out=0, Zero=1, Carry=0, Neg=0, multiplier counter/accumulator cleared; InReady=1 on the following cycle.
REQ-026 Reset SHALL take priority over any concurrent accept, retire or MULT step; an in-flight operation is discarded with no result produced.

Verification
REQ-027 W=8, ADD A=0xFF B=0x01, OutReady=1 -> next cycle OutValid=1, Out=0x00, Zero=1, Carry=1, Neg=0.
REQ-028 W=8, SUB A=0x03 B=0x05 -> Out=0xFE, Carry=1, Neg=1, Zero=0; then RSH A=0x81 B=0x01 -> Out=0x40, Carry=1; LSH A=0x81 B=0x00 -> Out=0x81, Carry=0.
REQ-029 W=8, MUL A=0x10 B=0x11 accepted at cycle 0 -> InReady=0 cycles 1-8, OutValid=1 at cycle 9, Out=0x10, Carry=1.
REQ-030 Backpressure: OutReady=0, ADD 0x02+0x03 accepted, second XOR request held on InValid -> Out=0x05 stable, InReady=0 until OutReady=1; on that cycle result retires and XOR accepted same edge; XOR result next cycle.
REQ-031 Reset asserted at cycle 4 of a MUL -> next cycle OutValid=0, InReady=1, Out=0, Zero=1; no MUL result ever appears.
REQ-032 Back-to-back non-MUL requests with InValid=1, OutReady=1 continuously -> one result per cycle, no bubbles, results in request order.
